// File: rtl/uk101_pkg.sv
// Shared types and helpers for the UK101 serial text injector.
package uk101_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GAP
  } tx_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Clock cycles per serial bit, truncated.
  function automatic logic [31:0] baud_div(input int unsigned clk_hz, input int unsigned baud);
    return 32'(clk_hz / baud);
  endfunction

endpackage

// File: rtl/uk101_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data, flush and occupancy count.
module uk101_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  wr_acc, rd_acc;

  assign full    = (count_q == CNT_MAX);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_acc   = wr_en & ~full;
    rd_acc   = rd_en & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uk101_text_injector.sv
// Feeds a downloaded text file to the UK101 ACIA as 8N1 serial, with a pause after each CR.
// Optional macro UK101_INJECT_LF_STRIP_EN drops 0x0A bytes before they enter the FIFO.
module uk101_text_injector
  import uk101_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD_HI    = 9600,
  parameter int BAUD_LO    = 300,
  parameter int DEPTH_LOG2 = 4,
  parameter int GAP_BITS   = 200
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       load_from,
  input  logic       baud_sel,
  input  logic       ioctl_download,
  input  logic       ioctl_wr,
  input  logic [7:0] ioctl_dout,
  output logic       ioctl_wait,
  input  logic       uart_rxd_in,
  output logic       rxd_out,
  output logic       busy
);

  localparam logic [31:0] DIV_HI   = baud_div(CLK_HZ, BAUD_HI);
  localparam logic [31:0] DIV_LO   = baud_div(CLK_HZ, BAUD_LO);
  localparam logic [31:0] GAP_LAST = 32'(GAP_BITS - 1);
  localparam logic [DEPTH_LOG2:0] WAIT_LVL = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2 - 1);
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2 + 1)'(1);

  tx_state_e             state_q, state_d;
  logic [31:0]           baud_cnt_q, baud_cnt_d;
  logic [31:0]           bit_cnt_q, bit_cnt_d;
  logic [31:0]           div_q, div_d;
  logic [7:0]            shift_q, shift_d;
  logic [7:0]            byte_q, byte_d;
  logic                  load_q;
  logic                  wait_q, wait_d;
  logic                  line, bit_end, load_rise;
  logic                  fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [7:0]            fifo_rd_data;
  logic [DEPTH_LOG2:0]   fifo_count, count_nxt;

  assign load_rise = load_from & ~load_q;

`ifdef UK101_INJECT_LF_STRIP_EN
  assign fifo_wr = ioctl_download & ioctl_wr & ~load_from & (ioctl_dout != ASCII_LF);
`else
  assign fifo_wr = ioctl_download & ioctl_wr & ~load_from;
`endif

  uk101_sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk_sys),
    .reset   (reset),
    .flush   (load_rise),
    .wr_en   (fifo_wr),
    .wr_data (ioctl_dout),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bit_end = (baud_cnt_q == div_q - 32'd1);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = '0;
    bit_cnt_d  = bit_cnt_q;
    div_d      = div_q;
    shift_d    = shift_q;
    byte_d     = byte_q;
    fifo_rd    = 1'b0;
    line       = 1'b1;
    if (state_q != ST_IDLE) baud_cnt_d = bit_end ? '0 : baud_cnt_q + 32'd1;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          shift_d = fifo_rd_data;
          byte_d  = fifo_rd_data;
          div_d   = baud_sel ? DIV_LO : DIV_HI;
          state_d = ST_START;
        end
      end
      ST_START: begin
        line = 1'b0;
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        line = shift_q[0];
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 32'd1;
          if (bit_cnt_q == 32'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = (byte_q == ASCII_CR) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 32'd1;
          if (bit_cnt_q == GAP_LAST) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_rise) begin
      state_d    = ST_IDLE;
      fifo_rd    = 1'b0;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
    end
  end

  // Wait is registered from next-cycle occupancy so it is already high in the cycle count reaches DEPTH-1.
  always_comb begin
    count_nxt = fifo_count;
    case ({fifo_wr & ~fifo_full, fifo_rd & ~fifo_empty})
      2'b10:   count_nxt = fifo_count + CNT_ONE;
      2'b01:   count_nxt = fifo_count - CNT_ONE;
      default: count_nxt = fifo_count;
    endcase
    if (load_rise) count_nxt = '0;
    wait_d = (count_nxt >= WAIT_LVL) || (state_d == ST_GAP);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      div_q      <= DIV_HI;
      shift_q    <= '0;
      byte_q     <= '0;
      load_q     <= 1'b0;
      wait_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      byte_q     <= byte_d;
      load_q     <= load_from;
      wait_q     <= wait_d;
    end
  end

  assign ioctl_wait = wait_q;
  assign rxd_out    = load_from ? uart_rxd_in : line;
  assign busy       = ~fifo_empty | (state_q != ST_IDLE);

endmodule

// File: doc/uk101_text_injector.md
UK101_TEXT_INJECTOR -- requirements
Module: uk101_text_injector

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_HI, default 9600, fast serial rate.
REQ-003 SHALL have parameter BAUD_LO, default 300, slow serial rate.
REQ-004 SHALL have parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes.
REQ-005 SHALL have parameter GAP_BITS, default 200, idle bit-times inserted after each 0x0D.
REQ-006 SHALL have port clk_sys  in  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port load_from  in  1  1 = UART passthrough, 0 = file injection.
REQ-009 SHALL have port baud_sel  in  1  0 = BAUD_HI, 1 = BAUD_LO.
REQ-010 SHALL have port ioctl_download  in  1  file transfer active.
REQ-011 SHALL have port ioctl_wr  in  1  byte strobe, one cycle per byte.
REQ-012 SHALL have port ioctl_dout  in  8  file byte.
REQ-013 SHALL have port ioctl_wait  out  1  back-pressure to the HPS file transfer.
REQ-014 SHALL have port uart_rxd_in  in  1  external serial line.
REQ-015 SHALL have port rxd_out  out  1  serial line to the ACIA receiver.
REQ-016 SHALL have port busy  out  1  injection in progress.

Function
REQ-017 SHALL write ioctl_dout into the FIFO on a cycle with ioctl_download & ioctl_wr & ~load_from & FIFO not full.
REQ-018 SHALL drop a write arriving while the FIFO is full; FIFO contents stay unchanged.
REQ-019 SHALL drive ioctl_wait registered, high when FIFO count >= DEPTH-1 or the FSM is in GAP, so that one in-flight write still fits.
REQ-020 SHALL leave count unchanged on a simultaneous FIFO write and read; pointers wrap modulo DEPTH.
REQ-021 SHALL derive bit period DIV = CLK_HZ/baud, truncated, from baud_sel, sampled only at the IDLE->START transition; mid-frame changes take effect on the next frame.
REQ-022 SHALL run FSM IDLE -> START (1 bit, line 0) -> DATA (8 bits, LSB first) -> STOP (1 bit, line 1) -> IDLE, or -> GAP when the byte was 0x0D.
REQ-023 SHALL leave GAP after GAP_BITS bit periods with the line held at 1, then go to IDLE.
REQ-024 SHALL pop the FIFO in the IDLE cycle where it is non-empty, with START line low beginning the next cycle.
REQ-025 SHALL drive rxd_out = uart_rxd_in when load_from=1, else the internal line; the internal line is 1 whenever the FSM is in IDLE.
REQ-026 SHALL, when load_from rises, flush the FIFO and force the FSM to IDLE on the same clock edge.
REQ-027 SHALL drive busy = FIFO non-empty OR FSM not in IDLE.

Reset
REQ-028 SHALL on reset empty the FIFO, set the FSM to IDLE and clear the bit and baud counters, with ioctl_wait=0, busy=0 and internal line=1 from the next cycle, including mid-frame.

Configuration
REQ-029 SHALL, with macro UK101_INJECT_LF_STRIP_EN defined, discard 0x0A bytes at the FIFO input (no write, no effect on ioctl_wait).
REQ-030 SHALL, without UK101_INJECT_LF_STRIP_EN, transmit every byte verbatim, 0x0A included.

Structure
REQ-031 SHALL take the FSM state enum, the ASCII_CR/ASCII_LF constants and a baud-divisor function from shared package uk101_pkg.
REQ-032 SHALL instantiate sub-module uk101_sync_fifo, parametrised by width 8 and DEPTH_LOG2, exposing full, empty and count.

Verification
REQ-033 SHALL cover: load_from=0, baud_sel=0, write 0x41 -> rxd_out low for 5208 cycles, then bits 1,0,0,0,0,0,1,0 at 5208 cycles each, then stop high; busy falls after stop.
REQ-034 SHALL cover: write 0x0D then 0x42 -> 0x42 start bit begins 200*5208 cycles after the 0x0D stop bit ends; ioctl_wait high throughout GAP.
REQ-035 SHALL cover: burst of 20 writes, DEPTH_LOG2=4 -> ioctl_wait high at count 15, no byte lost when the source honours it, 20 frames emitted in order.
REQ-036 SHALL cover: reset asserted in DATA bit 3 -> rxd_out=1, busy=0 next cycle, no further frames.
REQ-037 SHALL cover: load_from 0->1 with 5 bytes queued -> FIFO flushed, rxd_out follows uart_rxd_in in the same cycle.
REQ-038 SHALL cover: with UK101_INJECT_LF_STRIP_EN, input 0x0D,0x0A,0x43 -> exactly two frames (0x0D, 0x43); without it, three frames.
